// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input: buffers a payload, then sends header, payload, parity.
// Optional macro ROUTER_TX_ERR_INJECT_EN adds inject_err, which flips parity bit 0 of the packet.
module router_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    input  logic       busy,
`ifdef ROUTER_TX_ERR_INJECT_EN
    input  logic       inject_err,
`endif
    output logic       src_ready,
    output logic [7:0] datain,
    output logic       pkt_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       err_len
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HEADER,
        PAYLOAD,
        PARITY,
        GAP
    } state_t;

    localparam logic [5:0]  MAX_LEN_L = 6'(MAX_LEN);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  len_q;
    logic [1:0]  dest_q;
    logic [5:0]  wr_cnt;
    logic [5:0]  rd_cnt;
    logic [7:0]  parity;
    logic [15:0] gap_cnt;
    logic        inj_q;
    logic [7:0]  mem [0:MAX_LEN-1];
    logic        req_bad;
    logic        req_ok;
    logic        inj_in;

    assign req_bad = (len == 6'd0) || (len > MAX_LEN_L) || (dest == 2'd3);
    assign req_ok  = start && !req_bad;

`ifdef ROUTER_TX_ERR_INJECT_EN
    assign inj_in = inject_err;
`else
    assign inj_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs depend on registered state only; busy steers next-state alone.
    always_comb begin
        state_nxt = state;
        datain    = 8'h00;
        pkt_valid = 1'b0;
        src_ready = 1'b0;
        tx_ready  = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (req_ok) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                src_ready = 1'b1;
                if (src_valid && (wr_cnt == len_q - 6'd1)) begin
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                datain    = {len_q, dest_q};
                pkt_valid = 1'b1;
                if (!busy) begin
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                datain    = mem[rd_cnt];
                pkt_valid = 1'b1;
                if (!busy && (rd_cnt == len_q - 6'd1)) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                datain = parity ^ {7'b0, inj_q};
                if (!busy) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q   <= 6'd0;
            dest_q  <= 2'd0;
            wr_cnt  <= 6'd0;
            rd_cnt  <= 6'd0;
            parity  <= 8'h00;
            gap_cnt <= 16'd0;
            inj_q   <= 1'b0;
            done    <= 1'b0;
            err_len <= 1'b0;
        end else begin
            done    <= (state == PARITY) && !busy;
            err_len <= (state == IDLE) && start && req_bad;
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        len_q  <= len;
                        dest_q <= dest;
                        parity <= {len, dest};
                        wr_cnt <= 6'd0;
                        rd_cnt <= 6'd0;
                        inj_q  <= inj_in;
                    end
                end
                LOAD: begin
                    if (src_valid) begin
                        wr_cnt <= wr_cnt + 6'd1;
                        parity <= parity ^ src_data;
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        rd_cnt <= rd_cnt + 6'd1;
                    end
                end
                PARITY: begin
                    gap_cnt <= 16'd0;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; only written bytes are ever read back.
    always_ff @(posedge clk) begin
        if ((state == LOAD) && src_valid) begin
            mem[wr_cnt] <= src_data;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx (default parameters).
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] src_data;
    logic       src_valid;
    logic       busy;
    logic       inject_err;
    logic       src_ready;
    logic [7:0] datain;
    logic       pkt_valid;
    logic       tx_ready;
    logic       done;
    logic       err_len;

    router_pkt_tx dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dest      (dest),
        .len       (len),
        .src_data  (src_data),
        .src_valid (src_valid),
        .busy      (busy),
`ifdef ROUTER_TX_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .src_ready (src_ready),
        .datain    (datain),
        .pkt_valid (pkt_valid),
        .tx_ready  (tx_ready),
        .done      (done),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [7:0] pay [64];
    logic [7:0] rx [$];
    logic [7:0] par;
    int         par_seen, pv_seen, pv_cycles, hold3, done_cnt, err_cnt, pv_ever, txr_low;
    int         done_cyc, txr_rise;
    logic       txr_q;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        rx.delete();
        par = 8'h00; par_seen = 0; pv_seen = 0; pv_cycles = 0; hold3 = 0;
        done_cnt = 0; err_cnt = 0; pv_ever = 0; txr_low = 0;
        done_cyc = -100; txr_rise = -1; txr_q = 1'b1;
    endtask

    // Sample the current cycle (inputs already driven), then advance one clock.
    task automatic tick();
        if (pkt_valid) pv_cycles++;
        if (pkt_valid) pv_ever = 1;
        if (pkt_valid && !busy) rx.push_back(datain);
        if (!pkt_valid && !busy && pv_seen != 0) begin
            par = datain; par_seen++; pv_seen = 0;
        end
        if (pkt_valid) pv_seen = 1;
        if (pkt_valid && datain == 8'h03) hold3++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (err_len) err_cnt++;
        if (!tx_ready) txr_low = 1;
        if (tx_ready && !txr_q) txr_rise = cyc;
        txr_q = tx_ready;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [1:0] d, input int l, input bit toggle,
                        input logic [7:0] hold_byte, input int hold_n, input bit inj);
        int i, k, hc, b;
        bit fire;
        clr_mon();
        start = 1'b1; dest = d; len = 6'(l); inject_err = inj;
        tick();
        start = 1'b0; inject_err = 1'b0;
        i = 0; k = 0;
        while (i < l && k < 2000) begin
            src_valid = toggle ? (k % 2 == 0) : 1'b1;
            src_data  = pay[i];
            fire = src_valid && src_ready;
            tick();
            if (fire) i++;
            k++;
        end
        src_valid = 1'b0;
        check_eq("load_bytes", i, l);
        hc = 0; b = 0;
        while (done_cnt == 0 && b < 400) begin
            if (hc < hold_n && pkt_valid && datain == hold_byte) begin
                busy = 1'b1; hc++;
            end else begin
                busy = 1'b0;
            end
            tick();
            b++;
        end
        busy = 1'b0;
        b = 0;
        while (!tx_ready && b < 20) begin tick(); b++; end
        tick();
    endtask

    task automatic check_pkt(input int l, input logic [7:0] hdr, input logic [7:0] exp_par);
        check_eq("rx_count", rx.size(), l + 1);
        if (rx.size() > 0) check_eq("header", rx[0], hdr);
        for (int j = 0; j < l && j + 1 < rx.size(); j++) check_eq("payload", rx[j+1], pay[j]);
        check_eq("parity_seen", par_seen, 1);
        check_eq("parity", par, exp_par);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("gap_to_ready", txr_rise - done_cyc, 2);
    endtask

    initial begin
        logic [7:0] xp;
        logic [7:0] p1;
        reset = 1'b1; start = 1'b0; dest = 2'd0; len = 6'd0; src_data = 8'h00;
        src_valid = 1'b0; busy = 1'b0; inject_err = 1'b0;
        clr_mon();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_pkt_valid", pkt_valid, 0);
        check_eq("rst_datain", datain, 0);
        check_eq("rst_src_ready", src_ready, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err_len", err_len, 0);

        // Basic packet, dest 1, len 10, payload 1..10
        for (int j = 0; j < 10; j++) pay[j] = 8'(j + 1);
`ifdef ROUTER_TX_ERR_INJECT_EN
        p1 = 8'h23;
        send(2'd1, 10, 1'b0, 8'h00, 0, 1'b1);
`else
        p1 = 8'h22;
        send(2'd1, 10, 1'b0, 8'h00, 0, 1'b0);
`endif
        check_pkt(10, 8'h29, p1);
        check_eq("pv_cycles", pv_cycles, 11);

        // Same packet with a 3-cycle stall on payload byte 0x03
        send(2'd1, 10, 1'b0, 8'h03, 3, 1'b0);
        check_pkt(10, 8'h29, 8'h22);
        check_eq("hold_0x03", hold3, 4);
        check_eq("pv_cycles_busy", pv_cycles, 14);

        // Rejected requests
        clr_mon();
        start = 1'b1; dest = 2'd1; len = 6'd0;
        tick();
        start = 1'b0;
        tick(); tick();
        check_eq("err_len0", err_cnt, 1);
        start = 1'b1; dest = 2'd3; len = 6'd5;
        tick();
        start = 1'b0;
        tick(); tick();
        check_eq("err_dest3", err_cnt, 2);
        check_eq("err_txr_low", txr_low, 0);
        check_eq("err_pv_ever", pv_ever, 0);

        // Maximum length with gappy source
        xp = 8'hFD;
        for (int j = 0; j < 63; j++) begin
            pay[j] = 8'(j * 7 + 3);
            xp = xp ^ pay[j];
        end
        send(2'd1, 63, 1'b1, 8'h00, 0, 1'b0);
        check_pkt(63, 8'hFD, xp);
        check_eq("pv_cycles_63", pv_cycles, 64);

        // Reset during payload byte 5
        for (int j = 0; j < 10; j++) pay[j] = 8'(j + 1);
        clr_mon();
        start = 1'b1; dest = 2'd1; len = 6'd10;
        tick();
        start = 1'b0;
        src_valid = 1'b1;
        for (int j = 0; j < 10; j++) begin src_data = pay[j]; tick(); end
        src_valid = 1'b0;
        for (int b = 0; b < 20 && !(pkt_valid && datain == 8'h05); b++) tick();
        check_eq("rst_mid_reached", {pkt_valid, datain}, {1'b1, 8'h05});
        reset = 1'b1;
        tick();
        check_eq("rst_mid_pv", pkt_valid, 0);
        check_eq("rst_mid_datain", datain, 0);
        check_eq("rst_mid_txr", tx_ready, 1);
        reset = 1'b0;
        tick();

        // Short packet after the abandoned one: header 0x0A, parity 0x0A^0xA5^0x3C
        pay[0] = 8'hA5; pay[1] = 8'h3C;
        send(2'd2, 2, 1'b0, 8'h00, 0, 1'b0);
        check_pkt(2, 8'h0A, 8'h93);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
